// File: rtl/seg7_scan_decoder.sv
// Captures a scanned 4-digit seven-segment bus, debounces each digit window,
// decodes it back to BCD and presents the assembled word over valid/ready.
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ACCEPT_ALT69  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_word,
    output logic [3:0]  out_err,
    output logic        pat_err
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic {COLLECT, PRESENT} state_t;
    state_t state, state_nxt;

    logic [10:0]   sync1, cur, prev;
    logic [CW-1:0] cnt;
    logic          armed;
    logic [3:0]    captured;
    logic [3:0]    cur_an;
    logic [6:0]    cur_seg;
    logic          an_onehot;
    logic [1:0]    dig;
    logic [3:0]    dec_val;
    logic          dec_ill;
    logic          capture;
    logic          accept;

    assign cur_an  = cur[10:7];
    assign cur_seg = cur[6:0];

    always_comb begin
        an_onehot = 1'b1;
        dig       = 2'd0;
        case (cur_an)
            4'b0001: dig = 2'd0;
            4'b0010: dig = 2'd1;
            4'b0100: dig = 2'd2;
            4'b1000: dig = 2'd3;
            default: an_onehot = 1'b0;
        endcase
    end

    // No legal code maps to F, so F doubles as the illegal marker.
    always_comb begin
        dec_val = 4'hF;
        case (cur_seg)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            default:    dec_val = 4'hF;
        endcase
        if (ACCEPT_ALT69 && cur_seg == 7'b0011111) dec_val = 4'd6;
        if (ACCEPT_ALT69 && cur_seg == 7'b1110011) dec_val = 4'd9;
        dec_ill = (dec_val == 4'hF);
    end

    assign capture = (state == COLLECT) && (cur == prev) && (cnt == CNT_MAX) &&
                     armed && an_onehot && !captured[dig];
    assign accept  = (state == PRESENT) && out_ready;
    assign out_valid = (state == PRESENT);

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (capture && ((captured | (4'b0001 << dig)) == 4'hF)) state_nxt = PRESENT;
            PRESENT: if (out_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Window tracking keeps running in PRESENT so a held window can capture on return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            cur   <= '0;
            prev  <= '0;
            cnt   <= '0;
            armed <= 1'b0;
        end else begin
            sync1 <= {an_in, seg_in};
            cur   <= sync1;
            prev  <= cur;
            if (cur != prev) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                if (capture) armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            captured <= '0;
            out_word <= '0;
            out_err  <= '0;
            pat_err  <= 1'b0;
        end else begin
            pat_err <= capture && dec_ill;
            if (accept) begin
                captured <= '0;
                out_err  <= '0;
            end else if (capture) begin
                captured[dig]         <= 1'b1;
                out_word[dig*4 +: 4]  <= dec_val;
                out_err[dig]          <= dec_ill;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomised and directed bench for seg7_scan_decoder against a window-level
// reference model; runs an ACCEPT_ALT69=1 and an ACCEPT_ALT69=0 instance side by side.
module tb_seg7_scan_decoder;
    localparam int S = 4;
    localparam logic [6:0] SEG_TBL [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic        out_ready;
    logic        ov_a, ov_b, pe_a, pe_b;
    logic [15:0] ow_a, ow_b;
    logic [3:0]  oe_a, oe_b;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.STABLE_CYCLES(S), .ACCEPT_ALT69(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in), .out_ready(out_ready),
        .out_valid(ov_a), .out_word(ow_a), .out_err(oe_a), .pat_err(pe_a));

    seg7_scan_decoder #(.STABLE_CYCLES(S), .ACCEPT_ALT69(1'b0)) dut_na (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .an_in(an_in), .out_ready(out_ready),
        .out_valid(ov_b), .out_word(ow_b), .out_err(oe_b), .pat_err(pe_b));

    int n_chk = 0;
    int n_pass = 0;
    int rdy_mode = 1;
    int pe_cnt = 0;
    logic [15:0] last_acc;
    logic [3:0]  last_err;

    // Reference model: index 0 mirrors dut (alternates legal), index 1 mirrors dut_na.
    logic [10:0] hist[$];
    bit          consumed;
    bit          m_pres;
    logic [3:0]  m_mask;
    logic [15:0] m_word [2];
    logic [3:0]  m_err  [2];
    bit          m_pe   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void decode(input logic [6:0] s, input bit alt,
                                   output logic [3:0] nib, output bit ill);
        nib = 4'hF;
        ill = 1'b1;
        for (int v = 0; v < 10; v++)
            if (s == SEG_TBL[v]) begin nib = v[3:0]; ill = 1'b0; end
        if (alt && s == 7'b0011111) begin nib = 4'd6; ill = 1'b0; end
        if (alt && s == 7'b1110011) begin nib = 4'd9; ill = 1'b0; end
    endfunction

    function automatic void model_reset();
        hist.delete();
        repeat (3) hist.push_back('0);
        consumed = 1'b1;
        m_pres   = 1'b0;
        m_mask   = '0;
        for (int i = 0; i < 2; i++) begin
            m_word[i] = '0; m_err[i] = '0; m_pe[i] = 1'b0;
        end
    endfunction

    // A window is a run of identical synchronised samples; it may yield at most one
    // capture, once it has been visible for S+1 consecutive samples.
    function automatic void model_edge();
        logic [10:0] d, dp;
        int run, dg;
        logic [3:0] nib;
        bit ill;
        for (int i = 0; i < 2; i++) m_pe[i] = 1'b0;
        if (!rst_n) return;
        hist.push_back({an_in, seg_in});
        if (hist.size() > 24) void'(hist.pop_front());
        d  = hist[hist.size()-3];
        dp = hist[hist.size()-4];
        if (d != dp) consumed = 1'b0;
        run = 0;
        for (int i = hist.size()-3; i >= 0; i--) begin
            if (hist[i] != d) break;
            run++;
        end
        if (m_pres) begin
            if (out_ready) begin
                m_pres = 1'b0;
                m_mask = '0;
                for (int i = 0; i < 2; i++) m_err[i] = '0;
            end
        end else if (run >= S + 1 && !consumed && $countones(d[10:7]) == 1) begin
            dg = 0;
            for (int b = 0; b < 4; b++) if (d[7+b]) dg = b;
            if (!m_mask[dg]) begin
                consumed   = 1'b1;
                m_mask[dg] = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    decode(d[6:0], (i == 0), nib, ill);
                    m_word[i][dg*4 +: 4] = nib;
                    m_err[i][dg] = ill;
                    m_pe[i] = ill;
                end
                if (m_mask == 4'hF) m_pres = 1'b1;
            end
        end
    endfunction

    task automatic check_all();
        chk("valid_a", 32'(ov_a), 32'(m_pres));
        chk("word_a",  32'(ow_a), 32'(m_word[0]));
        chk("err_a",   32'(oe_a), 32'(m_err[0]));
        chk("pe_a",    32'(pe_a), 32'(m_pe[0]));
        chk("valid_b", 32'(ov_b), 32'(m_pres));
        chk("word_b",  32'(ow_b), 32'(m_word[1]));
        chk("err_b",   32'(oe_b), 32'(m_err[1]));
        chk("pe_b",    32'(pe_b), 32'(m_pe[1]));
    endtask

    task automatic cyc();
        if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else out_ready = (rdy_mode == 1);
        if (ov_a && out_ready) begin last_acc = ow_a; last_err = oe_a; end
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (pe_a) pe_cnt++;
    endtask

    task automatic win(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic digits(input logic [15:0] w, input int n);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] nv;
            nv = w[i*4 +: 4];
            win(4'(1 << i), SEG_TBL[nv], n);
        end
    endtask

    initial begin
        an_in = '0; seg_in = '0; out_ready = 1'b0; rst_n = 1'b0;
        last_acc = '0; last_err = '0;
        model_reset();
        #2;
        do_reset();
        chk("rst_word", 32'(ow_a), 32'h0);
        chk("rst_valid", 32'(ov_a), 32'h0);

        // 1: plain scan 1,2,3,4 with ready high
        rdy_mode = 1;
        digits(16'h4321, 8);
        win(4'b0000, 7'b0000000, 4);
        chk("t1_word", 32'(last_acc), 32'h4321);
        chk("t1_err",  32'(last_err), 32'h0);

        // 2: short window must not capture, the long one after it must
        do_reset();
        win(4'b0001, 7'b1111110, 3);
        win(4'b0001, 7'b1111111, 8);
        chk("t2_nib0", 32'(ow_a[3:0]), 32'h8);

        // 3: blank digit 2 inside a legal frame
        do_reset();
        pe_cnt = 0;
        win(4'b0001, SEG_TBL[5], 7);
        win(4'b0010, SEG_TBL[6], 7);
        win(4'b0100, 7'b0000000, 7);
        win(4'b1000, SEG_TBL[7], 7);
        win(4'b0000, 7'b0000000, 3);
        chk("t3_err", 32'(last_err), 32'h4);
        chk("t3_nib2", 32'(ow_a[11:8]), 32'hF);
        chk("t3_pulses", 32'(pe_cnt), 32'd1);

        // 4: stall with new digits on the bus, then release
        do_reset();
        rdy_mode = 0;
        digits(16'h1234, 7);
        digits(16'h5678, 6);
        chk("t4_held", 32'(ow_a), 32'h1234);
        chk("t4_vld",  32'(ov_a), 32'h1);
        rdy_mode = 1;
        cyc();
        chk("t4_first", 32'(last_acc), 32'h1234);
        digits(16'h5678, 7);
        win(4'b0000, 7'b0000000, 3);
        chk("t4_next", 32'(last_acc), 32'h5678);

        // 5: blanking/ghosting ignored, then the tail-less 6
        do_reset();
        win(4'b0011, SEG_TBL[1], 10);
        win(4'b0000, SEG_TBL[2], 10);
        win(4'b0010, 7'b0011111, 8);
        chk("t5_alt_nib", 32'(ow_a[7:4]), 32'h6);
        chk("t5_alt_err", 32'(oe_a), 32'h0);
        chk("t5_na_nib",  32'(ow_b[7:4]), 32'hF);
        chk("t5_na_err",  32'(oe_b), 32'h2);

        // 6: reset mid-frame discards the partial frame
        do_reset();
        win(4'b0001, SEG_TBL[1], 7);
        win(4'b0010, SEG_TBL[2], 7);
        win(4'b0100, SEG_TBL[3], 7);
        do_reset();
        chk("t6_word", 32'(ow_a), 32'h0);
        win(4'b1000, SEG_TBL[4], 8);
        chk("t6_novld", 32'(ov_a), 32'h0);
        digits(16'h9876, 7);

        // random windows with random ready
        rdy_mode = 2;
        for (int k = 0; k < 300; k++) begin
            logic [3:0] an;
            logic [6:0] sg;
            int r;
            r = $urandom_range(0, 9);
            if (r == 6) an = 4'b0000;
            else if (r == 7) begin
                do an = 4'($urandom_range(1, 15)); while ($countones(an) == 1);
            end else an = 4'(1 << $urandom_range(0, 3));
            r = $urandom_range(0, 11);
            if (r < 10) sg = SEG_TBL[r];
            else if (r == 10) sg = ($urandom_range(0, 1) != 0) ? 7'b0011111 : 7'b1110011;
            else sg = 7'($urandom_range(0, 127));
            if ({an, sg} == {an_in, seg_in}) sg = sg ^ 7'b0000001;
            win(an, sg, $urandom_range(2, 9));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
